rv32_trap_unit: RTL and testbench

Trap sequencer that sits directly upstream of the CSR bank's single write port and owns the bank's interrupt write path.
- Accepts synchronous exceptions, MRET and level interrupt lines from the core.
- Serialises the required mepc/mcause/mstatus updates over the one CSR write port, passing core CSR writes through when idle.
- Issues a pipeline flush and a PC redirect to the fetch stage.

---
 rtl/rv32_trap_unit_if.sv | 10 +
 rtl/rv32_trap_unit.sv | 189 ++++++++++++++++++
 tb/tb_rv32_trap_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_trap_unit_if.sv
// CSR write-port bundle: one write request (id + value).
// The core drives it into the trap unit; the trap unit drives the bank.
interface rv32_trap_unit_if;
  logic        write;
  logic [11:0] id;
  logic [31:0] value;

  modport master (output write, id, value);
  modport slave  (input  write, id, value);
endinterface

// File: rtl/rv32_trap_unit.sv
// Trap sequencer: serialises mepc/mcause/mstatus updates over the single
// CSR write port and issues a flush plus fetch redirect for traps and MRET.
module rv32_trap_unit #(
  parameter bit VECTORED_EN = 1'b1,
  parameter int EXC_CAUSE_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exc_valid,
  input  logic [EXC_CAUSE_W-1:0] exc_cause,
  input  logic [31:0]            exc_pc,
  input  logic                   mret_valid,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_pc,
  input  logic                   irq_ext,
  input  logic                   irq_sw,
  input  logic                   irq_timer,
  input  logic [2:0]             irq_enable,
  input  logic                   mstatus_mie,
  input  logic                   mstatus_mpie,
  input  logic [31:0]            mtvec,
  input  logic [31:0]            mepc,
  rv32_trap_unit_if.slave        core_csr,
  rv32_trap_unit_if.master       csr,
  output logic                   trap_accept,
  output logic                   busy,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   trap_taken
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MSTATUS,
    T_REDIR, R_MSTATUS, R_REDIR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        mie_q, mie_d;

  logic [2:0]  irq_pend;
  logic        irq_take;
  logic [30:0] irq_code;
  logic [31:0] trap_base;
  logic [31:0] trap_off;
  logic [31:0] trap_tgt;

  logic        wr;
  logic [11:0] wr_id;
  logic [31:0] wr_val;
  logic        rv;
  logic [31:0] rv_pc;
  logic        tt;
  logic        acc;
  logic        bsy;

  assign irq_pend = {irq_ext, irq_sw, irq_timer} & irq_enable;
  assign irq_take = mstatus_mie & commit_valid & (|irq_pend);

  always_comb begin
    irq_code = 31'd7;
    priority case (1'b1)
      irq_pend[2]: irq_code = 31'd11;
      irq_pend[1]: irq_code = 31'd3;
      default:     irq_code = 31'd7;
    endcase
  end

  // mtvec is read live, so a bank update earlier in the sequence is seen
  assign trap_base = {mtvec[31:2], 2'b00};
  assign trap_off  = (VECTORED_EN && mtvec[1:0] == 2'b01 && cause_q[31])
                   ? {cause_q[29:0], 2'b00} : 32'd0;
  assign trap_tgt  = trap_base + trap_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= 32'd0;
      cause_q <= 32'd0;
      mie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mie_q   <= mie_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mie_d   = mie_q;
    wr      = 1'b0;
    wr_id   = 12'd0;
    wr_val  = 32'd0;
    rv      = 1'b0;
    rv_pc   = 32'd0;
    tt      = 1'b0;
    acc     = 1'b0;
    bsy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        bsy    = 1'b0;
        wr     = core_csr.write;
        wr_id  = core_csr.id;
        wr_val = core_csr.value;
        if (exc_valid) begin
          acc     = 1'b1;
          pc_d    = exc_pc;
          cause_d = {1'b0, 31'(exc_cause)};
          mie_d   = mstatus_mie;
          state_d = W_MEPC;
        end else if (mret_valid) begin
          acc     = 1'b1;
          state_d = R_MSTATUS;
        end else if (irq_take) begin
          acc     = 1'b1;
          pc_d    = commit_pc;
          cause_d = {1'b1, irq_code};
          mie_d   = mstatus_mie;
          state_d = W_MEPC;
        end
      end
      W_MEPC: begin
        wr      = 1'b1;
        wr_id   = CSR_MEPC;
        wr_val  = {pc_q[31:2], 2'b00};
        state_d = W_MCAUSE;
      end
      W_MCAUSE: begin
        wr      = 1'b1;
        wr_id   = CSR_MCAUSE;
        wr_val  = cause_q;
        state_d = W_MSTATUS;
      end
      W_MSTATUS: begin
        wr      = 1'b1;
        wr_id   = CSR_MSTATUS;
        wr_val  = {24'd0, mie_q, 7'd0};
        state_d = T_REDIR;
      end
      T_REDIR: begin
        rv      = 1'b1;
        rv_pc   = trap_tgt;
        tt      = 1'b1;
        state_d = IDLE;
      end
      R_MSTATUS: begin
        wr      = 1'b1;
        wr_id   = CSR_MSTATUS;
        wr_val  = {24'd0, 1'b1, 3'd0, mstatus_mpie, 3'd0};
        state_d = R_REDIR;
      end
      R_REDIR: begin
        rv      = 1'b1;
        rv_pc   = {mepc[31:2], 2'b00};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a reset cycle must never leak a pass-through write or an accept
    if (reset) begin
      wr     = 1'b0;
      wr_id  = 12'd0;
      wr_val = 32'd0;
      rv     = 1'b0;
      rv_pc  = 32'd0;
      tt     = 1'b0;
      acc    = 1'b0;
      bsy    = 1'b0;
    end
  end

  assign csr.write      = wr;
  assign csr.id         = wr_id;
  assign csr.value      = wr_val;
  assign redirect_valid = rv;
  assign redirect_pc    = rv_pc;
  assign trap_taken     = tt;
  assign trap_accept    = acc;
  assign busy           = bsy;

endmodule

// File: tb/tb_rv32_trap_unit.sv
// Scoreboard bench for rv32_trap_unit: expected CSR writes and redirects
// are queued at stimulus time and popped as the DUT emits them.
module tb_rv32_trap_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        irq_ext, irq_sw, irq_timer;
  logic [2:0]  irq_enable;
  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mtvec, mepc;
  logic        trap_accept, busy, redirect_valid, trap_taken;
  logic [31:0] redirect_pc;

  rv32_trap_unit_if core_bus();
  rv32_trap_unit_if csr_bus();

  always #5 clk = ~clk;

  rv32_trap_unit #(.VECTORED_EN(1'b1), .EXC_CAUSE_W(5)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .irq_enable(irq_enable),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mtvec(mtvec), .mepc(mepc),
    .core_csr(core_bus.slave), .csr(csr_bus.master),
    .trap_accept(trap_accept), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_taken(trap_taken)
  );

  typedef struct {
    bit          redir;
    logic [11:0] id;
    logic [31:0] val;
    logic        tt;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic exp_csr(input logic [11:0] id, input logic [31:0] v);
    ev_t e;
    e.redir = 1'b0; e.id = id; e.val = v; e.tt = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_redir(input logic [31:0] pc, input logic t);
    ev_t e;
    e.redir = 1'b1; e.id = 12'd0; e.val = pc; e.tt = t;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] exp_tgt(input logic [31:0] tv,
                                          input logic intr,
                                          input logic [4:0] code);
    logic [31:0] base;
    base = {tv[31:2], 2'b00};
    if (intr && tv[1:0] == 2'b01) return base + 32'(code) * 32'd4;
    return base;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (csr_bus.write === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexp_csr", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("csr_kind", 32'(e.redir), 32'd0);
        chk("csr_id", 32'(csr_bus.id), 32'(e.id));
        chk("csr_val", csr_bus.value, e.val);
      end
    end
    if (redirect_valid === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexp_redir", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("redir_kind", 32'(e.redir), 32'd1);
        chk("redir_pc", redirect_pc, e.val);
        chk("trap_taken", 32'(trap_taken), 32'(e.tt));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr"}, 32'(csr_bus.write), 32'd0);
    chk({tag, "_rv"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_acc"}, 32'(trap_accept), 32'd0);
    chk({tag, "_tt"}, 32'(trap_taken), 32'd0);
  endtask

  task automatic run_seq(input string tag, input int n);
    tick;
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 1; i < n; i++) begin
      tick;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
    tick;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    exc_valid = 1'b0; exc_cause = 5'd0; exc_pc = 32'd0;
    mret_valid = 1'b0; commit_valid = 1'b0; commit_pc = 32'd0;
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
    irq_enable = 3'b000;
    mstatus_mie = 1'b0; mstatus_mpie = 1'b0;
    mtvec = 32'd0; mepc = 32'd0;
    core_bus.write = 1'b0; core_bus.id = 12'd0; core_bus.value = 32'd0;
    repeat (3) tick;
    chk_quiet("rst");
    reset = 1'b0;
    tick;

    // exception, direct mode
    mstatus_mie = 1'b1; mtvec = 32'h200;
    exc_valid = 1'b1; exc_cause = 5'd2; exc_pc = 32'h100;
    #1 chk("t1_acc", 32'(trap_accept), 32'd1);
    exp_csr(12'h341, 32'h100);
    exp_csr(12'h342, 32'h2);
    exp_csr(12'h300, 32'h80);
    exp_redir(exp_tgt(32'h200, 1'b0, 5'd2), 1'b1);
    run_seq("t1", 4);

    // timer interrupt, vectored
    mtvec = 32'h201; commit_valid = 1'b1; commit_pc = 32'h40;
    irq_enable = 3'b001; irq_timer = 1'b1;
    #1 chk("t2_acc", 32'(trap_accept), 32'd1);
    exp_csr(12'h341, 32'h40);
    exp_csr(12'h342, 32'h80000007);
    exp_csr(12'h300, 32'h80);
    exp_redir(exp_tgt(32'h201, 1'b1, 5'd7), 1'b1);
    run_seq("t2", 4);

    // timer interrupt, reserved mode 11 behaves as direct
    mtvec = 32'h203; irq_timer = 1'b1;
    #1 chk("t3_acc", 32'(trap_accept), 32'd1);
    exp_csr(12'h341, 32'h40);
    exp_csr(12'h342, 32'h80000007);
    exp_csr(12'h300, 32'h80);
    exp_redir(32'h200, 1'b1);
    run_seq("t3", 4);

    // ext beats timer, misaligned commit_pc masked
    mtvec = 32'h201; commit_pc = 32'h46;
    irq_enable = 3'b101; irq_ext = 1'b1; irq_timer = 1'b1;
    #1 chk("t4_acc", 32'(trap_accept), 32'd1);
    exp_csr(12'h341, 32'h44);
    exp_csr(12'h342, 32'h8000000B);
    exp_csr(12'h300, 32'h80);
    exp_redir(exp_tgt(32'h201, 1'b1, 5'd11), 1'b1);
    run_seq("t4", 4);

    // pending irq blocked by mie=0, then by commit_valid=0
    mstatus_mie = 1'b0; irq_timer = 1'b1; irq_enable = 3'b001;
    core_bus.write = 1'b1; core_bus.id = 12'h305; core_bus.value = 32'hABCD;
    exp_csr(12'h305, 32'hABCD);
    #1 chk("t5a_acc", 32'(trap_accept), 32'd0);
    tick;
    chk("t5a_busy", 32'(busy), 32'd0);
    mstatus_mie = 1'b1; commit_valid = 1'b0;
    core_bus.id = 12'h344; core_bus.value = 32'h5;
    exp_csr(12'h344, 32'h5);
    #1 chk("t5b_acc", 32'(trap_accept), 32'd0);
    tick;
    chk("t5b_busy", 32'(busy), 32'd0);
    core_bus.write = 1'b0; irq_timer = 1'b0;

    // MRET
    mstatus_mie = 1'b0; mstatus_mpie = 1'b1; mepc = 32'h3C;
    mret_valid = 1'b1;
    #1 chk("t6_acc", 32'(trap_accept), 32'd1);
    exp_csr(12'h300, 32'h88);
    exp_redir(32'h3C, 1'b0);
    run_seq("t6", 2);

    // exception wins over simultaneous MRET
    mtvec = 32'h200;
    exc_valid = 1'b1; exc_cause = 5'd4; exc_pc = 32'h103;
    mret_valid = 1'b1;
    #1 chk("t7_acc", 32'(trap_accept), 32'd1);
    exp_csr(12'h341, 32'h100);
    exp_csr(12'h342, 32'h4);
    exp_csr(12'h300, 32'h0);
    exp_redir(32'h200, 1'b1);
    run_seq("t7", 4);

    // core write passes in accept cycle; later requests are ignored
    mstatus_mie = 1'b1;
    exc_valid = 1'b1; exc_cause = 5'd5; exc_pc = 32'h80;
    core_bus.write = 1'b1; core_bus.id = 12'h340; core_bus.value = 32'h1234;
    exp_csr(12'h340, 32'h1234);
    exp_csr(12'h341, 32'h80);
    exp_csr(12'h342, 32'h5);
    exp_csr(12'h300, 32'h80);
    exp_redir(32'h200, 1'b1);
    #1 chk("t8_acc", 32'(trap_accept), 32'd1);
    tick;
    exc_valid = 1'b0;
    core_bus.id = 12'h305; core_bus.value = 32'hDEAD;
    chk("t8_busy1", 32'(busy), 32'd1);
    tick;
    core_bus.write = 1'b0;
    exc_valid = 1'b1; exc_cause = 5'd7; exc_pc = 32'h300;
    #1 chk("t8_acc2", 32'(trap_accept), 32'd0);
    tick;
    exc_valid = 1'b0;
    tick;
    chk("t8_busy4", 32'(busy), 32'd1);
    tick;
    chk("t8_idle", 32'(busy), 32'd0);

    // reset arriving in W_MCAUSE kills the rest of the sequence
    exc_valid = 1'b1; exc_cause = 5'd1; exc_pc = 32'h10;
    exp_csr(12'h341, 32'h10);
    #1 chk("t9_acc", 32'(trap_accept), 32'd1);
    tick;
    exc_valid = 1'b0;
    tick;
    reset = 1'b1;
    #1 chk_quiet("t9_in");
    tick;
    tick;
    tick;
    reset = 1'b0;
    #1 chk_quiet("t9_out");
    repeat (6) tick;
    chk("t9_idle", 32'(busy), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
